// File: rtl/mul4_tournament_sequencer.sv
// ---------------------------------------------------------------------------
// mul4_tournament_sequencer
//
// Scores a bank of candidate 2x2-bit vector multiplier datapaths and reports
// the fittest one. The block drives an exhaustive 16-lane stimulus onto the
// shared candidate bus, steps cand_sel through the candidates, registers each
// candidate's four 16-bit product outputs, and scores them against the golden
// product by counting matching bits (0..64 per candidate).
//
// Ports
//   clk              : rising-edge clock
//   rst_n            : asynchronous active-low reset
//   start            : request a tournament (honoured only while idle)
//   abort            : cancel a running scan, no result is published
//   cand_sel         : candidate index driven to the external mux
//   a1, a0, b1, b0   : 16-lane stimulus vectors (zero when not scanning)
//   y3, y2, y1, y0   : selected candidate's product bits, one lane per bit
//   busy             : high while candidates are being evaluated/scored
//   done             : one-cycle pulse, win_* valid in the same cycle
//   win_idx, win_fit : best candidate and its fitness, held until next done
//   perfect          : win_fit == 64, held with the result
// ---------------------------------------------------------------------------
module mul4_tournament_sequencer #(
   parameter int N_CAND     = 8,
   parameter int IDX_W      = $clog2(N_CAND),
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic [IDX_W-1:0] cand_sel,
   output logic [15:0]      a1,
   output logic [15:0]      a0,
   output logic [15:0]      b1,
   output logic [15:0]      b0,
   input  logic [15:0]      y3,
   input  logic [15:0]      y2,
   input  logic [15:0]      y1,
   input  logic [15:0]      y0,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] win_idx,
   output logic [6:0]       win_fit,
   output logic             perfect
);

   // Sequencer states
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_EVAL  = 2'd1;
   localparam logic [1:0] S_SCORE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // Lane i carries a = i[3:2], b = i[1:0]; these are the operand bit planes
   localparam logic [15:0] STIM_A1 = 16'hFF00;
   localparam logic [15:0] STIM_A0 = 16'hF0F0;
   localparam logic [15:0] STIM_B1 = 16'hCCCC;
   localparam logic [15:0] STIM_B0 = 16'hAAAA;

   // Product bit planes of a*b over the same 16 lanes
   localparam logic [15:0] GOLD_3 = 16'h8000;
   localparam logic [15:0] GOLD_2 = 16'h4C00;
   localparam logic [15:0] GOLD_1 = 16'h6AC0;
   localparam logic [15:0] GOLD_0 = 16'hA0A0;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CAND - 1);
   localparam logic [6:0]       FIT_MAX  = 7'd64;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] best_idx;
   logic [6:0]       best_fit;
   logic [15:0]      cap_y3;
   logic [15:0]      cap_y2;
   logic [15:0]      cap_y1;
   logic [15:0]      cap_y0;
   logic             busy_q;
   logic             done_q;

   logic [6:0]       fit;
   logic             fit_better;
   logic [6:0]       best_fit_nxt;
   logic [IDX_W-1:0] best_idx_nxt;
   logic             scan_last;

   // Number of ones in a 16-bit word, 0..16
   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = 5'd0;
      for (int i = 0; i < 16; i++) begin
         c = c + {4'd0, v[i]};
      end
      return c;
   endfunction

   // Fitness of the candidate captured during EVAL: count of product bits
   // that agree with the golden product over all lanes. Only meaningful in
   // SCORE, when the capture registers hold the current candidate.
   always_comb begin
      fit = {2'd0, popcount16(~(cap_y3 ^ GOLD_3))}
          + {2'd0, popcount16(~(cap_y2 ^ GOLD_2))}
          + {2'd0, popcount16(~(cap_y1 ^ GOLD_1))}
          + {2'd0, popcount16(~(cap_y0 ^ GOLD_0))};
   end

   // Best-so-far tracking. A strict comparison means an equal score never
   // displaces an earlier candidate, so ties resolve to the lower index.
   // The scan ends on the last candidate, or on a perfect score when early
   // exit is enabled.
   always_comb begin
      fit_better   = (fit > best_fit);
      best_fit_nxt = fit_better ? fit : best_fit;
      best_idx_nxt = fit_better ? idx : best_idx;
      scan_last    = (EARLY_EXIT && (fit == FIT_MAX)) || (idx == LAST_IDX);
   end

   // Next-state logic. Abort wins over everything while scanning and is
   // ignored in IDLE and DONE; start is only looked at in IDLE, so a start
   // arriving mid-scan or during DONE is simply dropped.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_EVAL;
         end
         S_EVAL: begin
            state_nxt = abort ? S_IDLE : S_SCORE;
         end
         S_SCORE: begin
            if (abort)          state_nxt = S_IDLE;
            else if (scan_last) state_nxt = S_DONE;
            else                state_nxt = S_EVAL;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State register plus registered busy/done flags. The flags are computed
   // from the next state so they line up exactly with EVAL/SCORE and DONE
   // without any decode logic on the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         busy_q <= (state_nxt == S_EVAL) || (state_nxt == S_SCORE);
         done_q <= (state_nxt == S_DONE);
      end
   end

   // Candidate index. It is cleared when a tournament starts, advanced only
   // when SCORE moves on to another EVAL, and otherwise left alone, which is
   // why cand_sel keeps showing the last candidate while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
      end else if ((state == S_IDLE) && start) begin
         idx <= '0;
      end else if ((state == S_SCORE) && !abort && !scan_last) begin
         idx <= idx + IDX_W'(1);
      end
   end

   // Capture the selected candidate's outputs at the end of its EVAL cycle,
   // so scoring works from stable registers rather than the external mux.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_y3 <= '0;
         cap_y2 <= '0;
         cap_y1 <= '0;
         cap_y0 <= '0;
      end else if ((state == S_EVAL) && !abort) begin
         cap_y3 <= y3;
         cap_y2 <= y2;
         cap_y1 <= y1;
         cap_y0 <= y0;
      end
   end

   // Best-so-far registers: zeroed at start so an all-zero-scoring bank
   // reports candidate 0 with fitness 0, then updated every SCORE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best_fit <= '0;
         best_idx <= '0;
      end else if ((state == S_IDLE) && start) begin
         best_fit <= '0;
         best_idx <= '0;
      end else if ((state == S_SCORE) && !abort) begin
         best_fit <= best_fit_nxt;
         best_idx <= best_idx_nxt;
      end
   end

   // Published result. It is loaded on the edge that enters DONE, using the
   // best values including the final SCORE cycle's update, so win_* and
   // perfect are already valid while done is high. An aborted scan never
   // reaches this load, leaving the previous result in place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_idx <= '0;
         win_fit <= '0;
         perfect <= 1'b0;
      end else if ((state == S_SCORE) && !abort && scan_last) begin
         win_idx <= best_idx_nxt;
         win_fit <= best_fit_nxt;
         perfect <= (best_fit_nxt == FIT_MAX);
      end
   end

   // Outputs. The stimulus vectors are gated by the registered busy flag,
   // so each bit is either a flop output or a constant zero.
   assign cand_sel = idx;
   assign busy     = busy_q;
   assign done     = done_q;
   assign a1       = busy_q ? STIM_A1 : 16'h0000;
   assign a0       = busy_q ? STIM_A0 : 16'h0000;
   assign b1       = busy_q ? STIM_B1 : 16'h0000;
   assign b0       = busy_q ? STIM_B0 : 16'h0000;

endmodule

// File: tb/tb_mul4_tournament_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mul4_tournament_sequencer
//
// Drives two copies of the sequencer side by side, one with early exit and
// one without, from the same candidate bank. The candidate bank is a table of
// four 16-bit output words per candidate, selected by each copy's cand_sel.
// Expected results come from a reference model that derives the golden
// product and stimulus from the lane definition and scores every candidate
// with plain bit counting.
// ---------------------------------------------------------------------------
module tb_mul4_tournament_sequencer;

   localparam int NC = 8;
   localparam int IW = 3;

   logic          clock;
   logic          rst_n;
   logic          start;
   logic          abort;

   logic [IW-1:0] candSel [2];
   logic [15:0]   vA1 [2];
   logic [15:0]   vA0 [2];
   logic [15:0]   vB1 [2];
   logic [15:0]   vB0 [2];
   logic [15:0]   yB3 [2];
   logic [15:0]   yB2 [2];
   logic [15:0]   yB1 [2];
   logic [15:0]   yB0 [2];
   logic          busyO [2];
   logic          doneO [2];
   logic [IW-1:0] winIdx [2];
   logic [6:0]    winFit [2];
   logic          perfectO [2];

   logic [15:0]   candY [NC][4];
   logic [15:0]   gold [4];
   logic [15:0]   stim [4];

   int            testCount;
   int            failCount;
   int            expIdx [2];
   int            expFit [2];
   int            expN [2];
   int            prevIdx [2];
   int            prevFit [2];

   // Copy 0 stops on a perfect score, copy 1 always scans every candidate
   mul4_tournament_sequencer #(.N_CAND(NC), .EARLY_EXIT(1'b1)) dutE (
      .clk(clock), .rst_n(rst_n), .start(start), .abort(abort),
      .cand_sel(candSel[0]),
      .a1(vA1[0]), .a0(vA0[0]), .b1(vB1[0]), .b0(vB0[0]),
      .y3(yB3[0]), .y2(yB2[0]), .y1(yB1[0]), .y0(yB0[0]),
      .busy(busyO[0]), .done(doneO[0]),
      .win_idx(winIdx[0]), .win_fit(winFit[0]), .perfect(perfectO[0])
   );

   mul4_tournament_sequencer #(.N_CAND(NC), .EARLY_EXIT(1'b0)) dutF (
      .clk(clock), .rst_n(rst_n), .start(start), .abort(abort),
      .cand_sel(candSel[1]),
      .a1(vA1[1]), .a0(vA0[1]), .b1(vB1[1]), .b0(vB0[1]),
      .y3(yB3[1]), .y2(yB2[1]), .y1(yB1[1]), .y0(yB0[1]),
      .busy(busyO[1]), .done(doneO[1]),
      .win_idx(winIdx[1]), .win_fit(winFit[1]), .perfect(perfectO[1])
   );

   // The external mux: each copy sees the candidate it selects
   assign yB3[0] = candY[candSel[0]][3];
   assign yB2[0] = candY[candSel[0]][2];
   assign yB1[0] = candY[candSel[0]][1];
   assign yB0[0] = candY[candSel[0]][0];
   assign yB3[1] = candY[candSel[1]][3];
   assign yB2[1] = candY[candSel[1]][2];
   assign yB1[1] = candY[candSel[1]][1];
   assign yB0[1] = candY[candSel[1]][0];

   // Free-running clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // One comparison: counted, asserted, reported on failure
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Golden product and stimulus straight from the lane definition
   task automatic buildReference();
      int a, b, p;
      for (int j = 0; j < 4; j++) begin
         gold[j] = '0;
         stim[j] = '0;
      end
      for (int i = 0; i < 16; i++) begin
         a = i >> 2;
         b = i & 3;
         p = a * b;
         for (int j = 0; j < 4; j++) gold[j][i] = 1'((p >> j) & 1);
         stim[0][i] = 1'((a >> 1) & 1);
         stim[1][i] = 1'(a & 1);
         stim[2][i] = 1'((b >> 1) & 1);
         stim[3][i] = 1'(b & 1);
      end
   endtask

   function automatic int fitOf(input int c);
      int f;
      f = 0;
      for (int j = 0; j < 4; j++) f += $countones(~(candY[c][j] ^ gold[j]));
      return f;
   endfunction

   // Tournament outcome for each copy: best score, lowest index on ties,
   // and how many candidates get evaluated
   task automatic modelTour();
      int best, bi, f;
      for (int u = 0; u < 2; u++) begin
         best = 0;
         bi   = 0;
         expN[u] = NC;
         for (int c = 0; c < NC; c++) begin
            f = fitOf(c);
            if (f > best) begin
               best = f;
               bi   = c;
            end
            if (u == 0 && f == 64) begin
               expN[u] = c + 1;
               break;
            end
         end
         expIdx[u] = bi;
         expFit[u] = best;
      end
   endtask

   task automatic fillBank(input logic [15:0] w);
      for (int c = 0; c < NC; c++)
         for (int j = 0; j < 4; j++) candY[c][j] = w;
   endtask

   task automatic setGolden(input int c);
      for (int j = 0; j < 4; j++) candY[c][j] = gold[j];
   endtask

   // Mix of exact, near-miss, random and constant candidates
   task automatic randomBank();
      int kind, j, bitPos;
      for (int c = 0; c < NC; c++) begin
         kind = $urandom_range(0, 3);
         case (kind)
            0: for (int k = 0; k < 4; k++) candY[c][k] = 16'($urandom);
            1: setGolden(c);
            2: begin
               setGolden(c);
               for (int n = 0; n < int'($urandom_range(1, 3)); n++) begin
                  j      = $urandom_range(0, 3);
                  bitPos = $urandom_range(0, 15);
                  candY[c][j][bitPos] = ~candY[c][j][bitPos];
               end
            end
            default: for (int k = 0; k < 4; k++)
               candY[c][k] = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000;
         endcase
      end
   endtask

   // Everything visible must be zero
   task automatic checkAllZero(input string tag);
      for (int u = 0; u < 2; u++) begin
         checkOutput($sformatf("%s u%0d cand_sel", tag, u), 64'(candSel[u]), 64'd0);
         checkOutput($sformatf("%s u%0d vectors", tag, u), {vA1[u], vA0[u], vB1[u], vB0[u]}, 64'd0);
         checkOutput($sformatf("%s u%0d busy", tag, u), 64'(busyO[u]), 64'd0);
         checkOutput($sformatf("%s u%0d done", tag, u), 64'(doneO[u]), 64'd0);
         checkOutput($sformatf("%s u%0d win_idx", tag, u), 64'(winIdx[u]), 64'd0);
         checkOutput($sformatf("%s u%0d win_fit", tag, u), 64'(winFit[u]), 64'd0);
         checkOutput($sformatf("%s u%0d perfect", tag, u), 64'(perfectO[u]), 64'd0);
      end
   endtask

   // Full tournament on the current bank, checked cycle by cycle. With
   // pulseMid set, extra start pulses land mid-scan and in the DONE cycle;
   // both must be dropped.
   task automatic applyStimulus(input string name, input bit pulseMid);
      int n;
      logic [63:0] stimAll;
      stimAll = {stim[0], stim[1], stim[2], stim[3]};
      modelTour();
      @(negedge clock);
      start = 1'b1;
      for (int k = 1; k <= 2 * NC + 3; k++) begin
         @(negedge clock);
         start = (pulseMid && (k == 3 || k == 2 * expN[0] + 1)) ? 1'b1 : 1'b0;
         for (int u = 0; u < 2; u++) begin
            n = expN[u];
            if (k <= 2 * n) begin
               checkOutput($sformatf("%s u%0d c%0d busy", name, u, k), 64'(busyO[u]), 64'd1);
               checkOutput($sformatf("%s u%0d c%0d done", name, u, k), 64'(doneO[u]), 64'd0);
               checkOutput($sformatf("%s u%0d c%0d cand_sel", name, u, k), 64'(candSel[u]), 64'((k - 1) / 2));
               checkOutput($sformatf("%s u%0d c%0d vectors", name, u, k), {vA1[u], vA0[u], vB1[u], vB0[u]}, stimAll);
               checkOutput($sformatf("%s u%0d c%0d held fit", name, u, k), 64'(winFit[u]), 64'(prevFit[u]));
               checkOutput($sformatf("%s u%0d c%0d held idx", name, u, k), 64'(winIdx[u]), 64'(prevIdx[u]));
            end else if (k == 2 * n + 1) begin
               checkOutput($sformatf("%s u%0d c%0d done", name, u, k), 64'(doneO[u]), 64'd1);
               checkOutput($sformatf("%s u%0d c%0d busy", name, u, k), 64'(busyO[u]), 64'd0);
               checkOutput($sformatf("%s u%0d win_idx", name, u), 64'(winIdx[u]), 64'(expIdx[u]));
               checkOutput($sformatf("%s u%0d win_fit", name, u), 64'(winFit[u]), 64'(expFit[u]));
               checkOutput($sformatf("%s u%0d perfect", name, u), 64'(perfectO[u]), 64'(expFit[u] == 64));
               checkOutput($sformatf("%s u%0d c%0d vectors", name, u, k), {vA1[u], vA0[u], vB1[u], vB0[u]}, 64'd0);
            end else begin
               checkOutput($sformatf("%s u%0d c%0d done", name, u, k), 64'(doneO[u]), 64'd0);
               checkOutput($sformatf("%s u%0d c%0d busy", name, u, k), 64'(busyO[u]), 64'd0);
               checkOutput($sformatf("%s u%0d c%0d idle sel", name, u, k), 64'(candSel[u]), 64'(n - 1));
               checkOutput($sformatf("%s u%0d c%0d kept fit", name, u, k), 64'(winFit[u]), 64'(expFit[u]));
            end
         end
      end
      start = 1'b0;
      for (int u = 0; u < 2; u++) begin
         prevIdx[u] = expIdx[u];
         prevFit[u] = expFit[u];
      end
   endtask

   // Abort during the SCORE cycle of candidate 3; nothing is published
   task automatic applyAbort();
      logic [63:0] stimAll;
      stimAll = {stim[0], stim[1], stim[2], stim[3]};
      @(negedge clock);
      start = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clock);
         start = 1'b0;
         abort = (k == 8) ? 1'b1 : 1'b0;
         for (int u = 0; u < 2; u++) begin
            checkOutput($sformatf("abort u%0d c%0d done", u, k), 64'(doneO[u]), 64'd0);
            checkOutput($sformatf("abort u%0d c%0d win_fit", u, k), 64'(winFit[u]), 64'(prevFit[u]));
            checkOutput($sformatf("abort u%0d c%0d win_idx", u, k), 64'(winIdx[u]), 64'(prevIdx[u]));
            checkOutput($sformatf("abort u%0d c%0d perfect", u, k), 64'(perfectO[u]), 64'(prevFit[u] == 64));
            if (k <= 8) begin
               checkOutput($sformatf("abort u%0d c%0d busy", u, k), 64'(busyO[u]), 64'd1);
               checkOutput($sformatf("abort u%0d c%0d cand_sel", u, k), 64'(candSel[u]), 64'((k - 1) / 2));
               checkOutput($sformatf("abort u%0d c%0d vectors", u, k), {vA1[u], vA0[u], vB1[u], vB0[u]}, stimAll);
            end else begin
               checkOutput($sformatf("abort u%0d c%0d busy", u, k), 64'(busyO[u]), 64'd0);
               checkOutput($sformatf("abort u%0d c%0d cand_sel", u, k), 64'(candSel[u]), 64'd3);
               checkOutput($sformatf("abort u%0d c%0d vectors", u, k), {vA1[u], vA0[u], vB1[u], vB0[u]}, 64'd0);
            end
         end
      end
      abort = 1'b0;
   endtask

   // Reset asserted in the EVAL cycle of candidate 1
   task automatic applyReset();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (2) @(negedge clock);
      checkOutput("pre-reset busy", 64'(busyO[0]), 64'd1);
      #2 rst_n = 1'b0;
      #1 checkAllZero("async reset");
      @(negedge clock);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         for (int u = 0; u < 2; u++) begin
            checkOutput($sformatf("post-reset u%0d c%0d busy", u, k), 64'(busyO[u]), 64'd0);
            checkOutput($sformatf("post-reset u%0d c%0d done", u, k), 64'(doneO[u]), 64'd0);
            checkOutput($sformatf("post-reset u%0d c%0d cand_sel", u, k), 64'(candSel[u]), 64'd0);
         end
      end
      for (int u = 0; u < 2; u++) begin
         prevIdx[u] = 0;
         prevFit[u] = 0;
      end
   endtask

   initial begin
      testCount = 0;
      failCount = 0;
      start     = 1'b0;
      abort     = 1'b0;
      rst_n     = 1'b0;
      buildReference();
      fillBank(16'h0000);
      for (int u = 0; u < 2; u++) begin
         prevIdx[u] = 0;
         prevFit[u] = 0;
      end

      // Reset state
      #1 checkAllZero("reset");
      #20;
      @(negedge clock);
      rst_n = 1'b1;
      @(negedge clock);
      checkAllZero("after release");

      // Every candidate outputs zeros
      fillBank(16'h0000);
      applyStimulus("zeros", 1'b0);

      // Candidate 5 exact, others all ones; ignored start pulses included
      fillBank(16'hFFFF);
      setGolden(5);
      applyStimulus("golden5", 1'b1);

      // Tie between candidates 2 and 6, one bit off each
      fillBank(16'h0000);
      setGolden(2);
      setGolden(6);
      candY[2][0][0] = ~candY[2][0][0];
      candY[6][0][0] = ~candY[6][0][0];
      applyStimulus("tie", 1'b0);

      // Abort keeps the tie result, then a fresh scan completes
      fillBank(16'h0000);
      applyAbort();
      fillBank(16'hFFFF);
      setGolden(0);
      applyStimulus("after abort", 1'b0);

      // Asynchronous reset mid-scan, then a normal run
      fillBank(16'h0000);
      applyReset();
      setGolden(7);
      applyStimulus("after reset", 1'b0);

      // Randomized banks
      for (int r = 0; r < 20; r++) begin
         randomBank();
         applyStimulus($sformatf("rand%0d", r), r[0]);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
